// File: rtl/vpu_job_sequencer.sv
// rtl/vpu_job_sequencer.sv - job-level controller for one vpu_channel (K-tile accumulate, final, drain)
// Optional VPU_JOB_SEQ_PERF_EN adds the perf_busy_cycles counter output.
module vpu_job_sequencer #(
  parameter int BATCH_SIZE = 16,
  parameter int TILE_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [TILE_W-1:0] cmd_num_tiles,
  input  logic              cmd_bias_en,
  input  logic              cmd_relu_en,
  input  logic              cmd_dequant_en,
  input  logic [31:0]       cmd_scale,
  input  logic              sa_beat,
  input  logic              out_beat,
  output logic [1:0]        mode_select,
  output logic              psum_clear,
  output logic              psum_enable,
  output logic              bias_enable,
  output logic              relu_enable,
  output logic              dequant_enable,
  output logic [31:0]       scale_fp32,
  output logic [TILE_W-1:0] tile_idx,
  output logic              busy,
  output logic              done,
`ifdef VPU_JOB_SEQ_PERF_EN
  output logic [31:0]       perf_busy_cycles,
`endif
  output logic              err_beat
);

  localparam int CW = $clog2(BATCH_SIZE) + 1;
  localparam logic [CW-1:0] BS_C = CW'(BATCH_SIZE);
  localparam logic [TILE_W-1:0] ONE_T = TILE_W'(1);

  typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, FINAL, DRAIN, DONE} state_t;

  state_t            state, state_d;
  logic [CW-1:0]     beat_cnt, out_cnt, out_cnt_d;
  logic [TILE_W-1:0] ntiles;
  logic              bias_l, relu_l, deq_l;
  logic [31:0]       scale_l;
  logic              accept, sa_active, beat_last;

  assign accept    = cmd_valid && (state == IDLE);
  assign sa_active = (state == ACCUM) || (state == FINAL);
  assign beat_last = sa_beat && sa_active && (beat_cnt == BS_C - CW'(1));

  // Output beats are only counted from FINAL entry and saturate at BATCH_SIZE.
  always_comb begin
    out_cnt_d = out_cnt;
    if (((state == FINAL) || (state == DRAIN)) && out_beat && (out_cnt != BS_C))
      out_cnt_d = out_cnt + CW'(1);
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (cmd_valid) state_d = CLEAR;
      CLEAR:   state_d = (ntiles > ONE_T) ? ACCUM : FINAL;
      ACCUM:   if (beat_last && ((tile_idx + ONE_T) == (ntiles - ONE_T))) state_d = FINAL;
      FINAL:   if (beat_last) state_d = DRAIN;
      DRAIN:   if (out_cnt_d == BS_C) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_cnt <= '0;
      out_cnt  <= '0;
      tile_idx <= '0;
      ntiles   <= '0;
      bias_l   <= 1'b0;
      relu_l   <= 1'b0;
      deq_l    <= 1'b0;
      scale_l  <= '0;
      err_beat <= 1'b0;
    end else if (accept) begin
      beat_cnt <= '0;
      out_cnt  <= '0;
      tile_idx <= '0;
      ntiles   <= (cmd_num_tiles == '0) ? ONE_T : cmd_num_tiles;
      bias_l   <= cmd_bias_en;
      relu_l   <= cmd_relu_en;
      deq_l    <= cmd_dequant_en;
      scale_l  <= cmd_scale;
      err_beat <= 1'b0;
    end else begin
      out_cnt <= out_cnt_d;
      if (sa_beat && sa_active) begin
        beat_cnt <= beat_last ? '0 : beat_cnt + CW'(1);
        if (beat_last && (state == ACCUM)) tile_idx <= tile_idx + ONE_T;
      end
      if (sa_beat && !sa_active) err_beat <= 1'b1;
    end
  end

  // Moore outputs: all controls follow the registered state.
  assign cmd_ready      = (state == IDLE);
  assign busy           = (state != IDLE);
  assign done           = (state == DONE);
  assign psum_clear     = (state == CLEAR);
  assign psum_enable    = sa_active;
  assign mode_select    = (state == ACCUM) ? 2'b01 :
                          ((state == FINAL) || (state == DRAIN)) ? 2'b10 : 2'b00;
  assign bias_enable    = bias_l && ((state == FINAL) || (state == DRAIN));
  assign relu_enable    = relu_l && ((state == FINAL) || (state == DRAIN));
  assign dequant_enable = deq_l  && ((state == FINAL) || (state == DRAIN));
  assign scale_fp32     = scale_l;

`ifdef VPU_JOB_SEQ_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                   perf_busy_cycles <= '0;
    else if (busy && (perf_busy_cycles != '1)) perf_busy_cycles <= perf_busy_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_vpu_job_sequencer.sv
// tb/tb_vpu_job_sequencer.sv - directed self-checking bench for vpu_job_sequencer
module tb_vpu_job_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_num_tiles = '0;
  logic        cmd_bias_en = 1'b0, cmd_relu_en = 1'b0, cmd_dequant_en = 1'b0;
  logic [31:0] cmd_scale = '0;
  logic        sa_beat = 1'b0, out_beat = 1'b0;
  logic [1:0]  mode_select;
  logic        psum_clear, psum_enable, bias_enable, relu_enable, dequant_enable;
  logic [31:0] scale_fp32;
  logic [7:0]  tile_idx;
  logic        busy, done, err_beat;
`ifdef VPU_JOB_SEQ_PERF_EN
  logic [31:0] perf_busy_cycles;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  vpu_job_sequencer #(.BATCH_SIZE(16), .TILE_W(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_num_tiles(cmd_num_tiles),
    .cmd_bias_en(cmd_bias_en), .cmd_relu_en(cmd_relu_en), .cmd_dequant_en(cmd_dequant_en),
    .cmd_scale(cmd_scale), .sa_beat(sa_beat), .out_beat(out_beat),
    .mode_select(mode_select), .psum_clear(psum_clear), .psum_enable(psum_enable),
    .bias_enable(bias_enable), .relu_enable(relu_enable), .dequant_enable(dequant_enable),
    .scale_fp32(scale_fp32), .tile_idx(tile_idx), .busy(busy), .done(done),
`ifdef VPU_JOB_SEQ_PERF_EN
    .perf_busy_cycles(perf_busy_cycles),
`endif
    .err_beat(err_beat)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic sa, input logic ob);
    sa_beat  = sa;
    out_beat = ob;
    tick();
    sa_beat  = 1'b0;
    out_beat = 1'b0;
  endtask

  task automatic start_job(input logic [7:0] nt, input logic b, input logic r,
                           input logic d, input logic [31:0] sc);
    cmd_valid = 1'b1; cmd_num_tiles = nt;
    cmd_bias_en = b; cmd_relu_en = r; cmd_dequant_en = d; cmd_scale = sc;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    tests++; if ({cmd_ready, busy, done, psum_clear, psum_enable, err_beat} !== 6'b100000) begin
      fails++; $display("FAIL reset_flags got %b exp 100000", {cmd_ready, busy, done, psum_clear, psum_enable, err_beat}); end
    tests++; if ({mode_select, tile_idx, scale_fp32} !== 42'd0) begin
      fails++; $display("FAIL reset_values got %0h exp 0", {mode_select, tile_idx, scale_fp32}); end
    tick(); tick();
    rst = 1'b1;
    tick();
    tests++; if ({cmd_ready, busy} !== 2'b10) begin
      fails++; $display("FAIL reset_release got %b exp 10", {cmd_ready, busy}); end
  endtask

  task automatic test_multi_tile();
    start_job(8'd3, 1'b1, 1'b0, 1'b1, 32'h3F00_0000);
    tests++; if ({psum_clear, mode_select, cmd_ready, busy} !== 5'b1_00_01) begin
      fails++; $display("FAIL mt_clear got %b exp 10001", {psum_clear, mode_select, cmd_ready, busy}); end
    tick();
    tests++; if ({psum_clear, mode_select, psum_enable, tile_idx} !== {1'b0, 2'b01, 1'b1, 8'd0}) begin
      fails++; $display("FAIL mt_accum0 got %0h exp %0h", {psum_clear, mode_select, psum_enable, tile_idx}, {1'b0, 2'b01, 1'b1, 8'd0}); end
    tests++; if ({bias_enable, relu_enable, dequant_enable} !== 3'b000) begin
      fails++; $display("FAIL mt_accum_en got %b exp 000", {bias_enable, relu_enable, dequant_enable}); end
    for (int i = 0; i < 15; i++) step(1'b1, 1'b0);
    tests++; if ({mode_select, tile_idx} !== {2'b01, 8'd0}) begin
      fails++; $display("FAIL mt_beat15 got %0h exp %0h", {mode_select, tile_idx}, {2'b01, 8'd0}); end
    step(1'b1, 1'b0);
    tests++; if ({mode_select, tile_idx} !== {2'b01, 8'd1}) begin
      fails++; $display("FAIL mt_accum1 got %0h exp %0h", {mode_select, tile_idx}, {2'b01, 8'd1}); end
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0);
    tests++; if ({mode_select, psum_enable, tile_idx} !== {2'b10, 1'b1, 8'd2}) begin
      fails++; $display("FAIL mt_final got %0h exp %0h", {mode_select, psum_enable, tile_idx}, {2'b10, 1'b1, 8'd2}); end
    tests++; if ({bias_enable, relu_enable, dequant_enable} !== 3'b101) begin
      fails++; $display("FAIL mt_final_en got %b exp 101", {bias_enable, relu_enable, dequant_enable}); end
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1);
    tests++; if ({mode_select, psum_enable, bias_enable, relu_enable, dequant_enable, done, tile_idx} !== {2'b10, 5'b01010, 8'd2}) begin
      fails++; $display("FAIL mt_drain got %0h exp %0h", {mode_select, psum_enable, bias_enable, relu_enable, dequant_enable, done, tile_idx}, {2'b10, 5'b01010, 8'd2}); end
    tick();
    tests++; if ({done, mode_select, cmd_ready, busy} !== 5'b1_00_01) begin
      fails++; $display("FAIL mt_done got %b exp 10001", {done, mode_select, cmd_ready, busy}); end
    tick();
    tests++; if ({done, cmd_ready, busy, bias_enable, dequant_enable} !== 5'b01000) begin
      fails++; $display("FAIL mt_idle got %b exp 01000", {done, cmd_ready, busy, bias_enable, dequant_enable}); end
    tests++; if (scale_fp32 !== 32'h3F00_0000) begin
      fails++; $display("FAIL mt_scale_held got %h exp 3f000000", scale_fp32); end
  endtask

  task automatic test_zero_tiles();
    start_job(8'd0, 1'b0, 1'b1, 1'b0, 32'h4000_0000);
    tick();
    tests++; if ({mode_select, tile_idx, relu_enable} !== {2'b10, 8'd0, 1'b1}) begin
      fails++; $display("FAIL zt_final got %0h exp %0h", {mode_select, tile_idx, relu_enable}, {2'b10, 8'd0, 1'b1}); end
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1);
    tests++; if ({mode_select, psum_enable, done} !== 4'b10_0_0) begin
      fails++; $display("FAIL zt_drain got %b exp 1000", {mode_select, psum_enable, done}); end
    tick();
    tests++; if ({done, tile_idx} !== {1'b1, 8'd0}) begin
      fails++; $display("FAIL zt_done got %0h exp %0h", {done, tile_idx}, {1'b1, 8'd0}); end
    tick();
  endtask

  task automatic test_late_out();
    start_job(8'd1, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    tests++; if (mode_select !== 2'b10) begin
      fails++; $display("FAIL lo_final got %b exp 10", mode_select); end
    for (int i = 0; i < 18; i++) step(i < 16, i >= 3);
    tests++; if ({mode_select, psum_enable, done, busy} !== 5'b10_0_0_1) begin
      fails++; $display("FAIL lo_drain_hold got %b exp 10001", {mode_select, psum_enable, done, busy}); end
    step(1'b0, 1'b1);
    tests++; if ({done, mode_select} !== 3'b1_00) begin
      fails++; $display("FAIL lo_done got %b exp 100", {done, mode_select}); end
    tick();
    tests++; if ({cmd_ready, done} !== 2'b10) begin
      fails++; $display("FAIL lo_idle got %b exp 10", {cmd_ready, done}); end
  endtask

  task automatic test_err_beat();
    step(1'b1, 1'b0);
    tick(); tick();
    tests++; if (err_beat !== 1'b1) begin
      fails++; $display("FAIL err_idle got %b exp 1", err_beat); end
    start_job(8'd1, 1'b0, 1'b0, 1'b0, 32'h0);
    tests++; if (err_beat !== 1'b0) begin
      fails++; $display("FAIL err_cleared got %b exp 0", err_beat); end
    tick();
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    tests++; if ({err_beat, mode_select} !== 3'b1_10) begin
      fails++; $display("FAIL err_drain got %b exp 110", {err_beat, mode_select}); end
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1);
    tick();
  endtask

  task automatic test_back_to_back();
    start_job(8'd1, 1'b0, 1'b0, 1'b0, 32'h1111_1111);
    tick();
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1);
    cmd_valid = 1'b1; cmd_num_tiles = 8'd2; cmd_scale = 32'h2222_2222;
    tick();
    tests++; if ({done, cmd_ready, scale_fp32} !== {2'b10, 32'h1111_1111}) begin
      fails++; $display("FAIL b2b_done got %0h exp %0h", {done, cmd_ready, scale_fp32}, {2'b10, 32'h1111_1111}); end
    tick();
    tests++; if ({cmd_ready, busy, done} !== 3'b100) begin
      fails++; $display("FAIL b2b_gap got %b exp 100", {cmd_ready, busy, done}); end
    tick();
    cmd_valid = 1'b0;
    tests++; if ({psum_clear, scale_fp32} !== {1'b1, 32'h2222_2222}) begin
      fails++; $display("FAIL b2b_accept got %0h exp %0h", {psum_clear, scale_fp32}, {1'b1, 32'h2222_2222}); end
    tick();
    tests++; if ({mode_select, tile_idx} !== {2'b01, 8'd0}) begin
      fails++; $display("FAIL b2b_accum got %0h exp %0h", {mode_select, tile_idx}, {2'b01, 8'd0}); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    #2 rst = 1'b0;
    #1;
    tests++; if ({cmd_ready, busy, done, psum_enable, mode_select} !== 6'b100000) begin
      fails++; $display("FAIL rm_async got %b exp 100000", {cmd_ready, busy, done, psum_enable, mode_select}); end
    tests++; if ({tile_idx, scale_fp32, err_beat} !== 41'd0) begin
      fails++; $display("FAIL rm_latches got %0h exp 0", {tile_idx, scale_fp32, err_beat}); end
    tick(); tick();
    tests++; if ({done, busy} !== 2'b00) begin
      fails++; $display("FAIL rm_no_done got %b exp 00", {done, busy}); end
    rst = 1'b1;
    tick();
    tests++; if ({cmd_ready, done} !== 2'b10) begin
      fails++; $display("FAIL rm_release got %b exp 10", {cmd_ready, done}); end
  endtask

`ifdef VPU_JOB_SEQ_PERF_EN
  task automatic perf_job();
    start_job(8'd1, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    for (int i = 0; i < 18; i++) step(i < 16, i >= 2);
    tick();
    tick();
  endtask

  task automatic test_perf();
    rst = 1'b0; tick(); rst = 1'b1; tick();
    perf_job();
    tests++; if (perf_busy_cycles !== 32'd20) begin
      fails++; $display("FAIL perf_one got %0d exp 20", perf_busy_cycles); end
    perf_job();
    tests++; if (perf_busy_cycles !== 32'd40) begin
      fails++; $display("FAIL perf_two got %0d exp 40", perf_busy_cycles); end
  endtask
`endif

  initial begin
    test_reset();
    test_multi_tile();
    test_zero_tiles();
    test_late_out();
    test_err_beat();
    test_back_to_back();
    test_reset_mid();
`ifdef VPU_JOB_SEQ_PERF_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
